// File: rtl/serial_alu_param_if.sv
// serial_alu_param_if -- request/result bus of the digit-serial ALU.
//   master : drives start/opcode/a/b, observes busy/done/c and flags
//   slave  : the ALU itself
// Signals:
//   start  request strobe            opcode 3-bit operation select
//   a, b   WIDTH-bit operands        busy   operation in progress
//   done   one-cycle completion      c      WIDTH-bit result
//   zf/sf/cf  zero / sign / carry (no-borrow) flags
//   vf     signed overflow, present only when SERIAL_ALU_OVF_EN is defined
interface serial_alu_param_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] c;
  logic             zf;
  logic             sf;
  logic             cf;
`ifdef SERIAL_ALU_OVF_EN
  logic             vf;
`endif

  modport master (
    output start, opcode, a, b,
    input  busy, done, c, zf, sf, cf
`ifdef SERIAL_ALU_OVF_EN
    , input vf
`endif
  );

  modport slave (
    input  start, opcode, a, b,
    output busy, done, c, zf, sf, cf
`ifdef SERIAL_ALU_OVF_EN
    , output vf
`endif
  );
endinterface

// File: rtl/serial_alu_param.sv
// serial_alu_param -- multi-cycle digit-serial 8-op ALU.
// Consumes DIGIT bits of the latched operands per clock, LSB first, with the
// ripple carry held in a register between digits. One operation takes
// N = WIDTH/DIGIT RUN cycles; results and flags update only on DONE.
// Parameters: WIDTH (>=2) operand width; DIGIT bits per clock, divides WIDTH.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_alu_param_if.slave (start/opcode/a/b in; busy/done/c/flags out)
// Optional feature: define SERIAL_ALU_OVF_EN to add the signed-overflow flag vf.
// Opcodes: 000 NOP, 001 XOR, 010 ADD, 011 XNOR, 100 SUB, 101 AND, 110 OR, 111 PASS A.

// One bit of the digit slice: logic result or full-adder sum/carry.
module serial_alu_bit (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       ci,
  output logic       r,
  output logic       co
);
  logic bb, s, cg;

  // SUB is A + ~B with carry-in 1 on the first digit.
  assign bb = (op == 3'b100) ? ~b : b;
  assign s  = a ^ bb ^ ci;
  assign cg = (a & bb) | (ci & (a ^ bb));

  always_comb begin
    r  = 1'b0;
    co = 1'b0;
    case (op)
      3'b001:         r = a ^ b;
      3'b010, 3'b100: begin r = s; co = cg; end
      3'b011:         r = ~(a ^ b);
      3'b101:         r = a & b;
      3'b110:         r = a | b;
      3'b111:         r = a;
      default:        r = 1'b0;
    endcase
  end
endmodule

module serial_alu_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst_n,
  serial_alu_param_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Latched request; the a/b fields shift right one digit per RUN cycle.
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state_q, state_d;
  logic             accept, last;
  req_t             req_q;
  logic [WIDTH-1:0] res_q, res_next, dig_ext;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, zf_q, sf_q, cf_q;
  logic [WIDTH-1:0] c_q;
  logic [DIGIT:0]   cy;
  logic [DIGIT-1:0] dig_r;
  logic             arith;
`ifdef SERIAL_ALU_OVF_EN
  logic             vf_q;
`endif

  assign arith = (req_q.op == OP_ADD) || (req_q.op == OP_SUB);
  assign cy[0] = carry_q;

  generate
    for (genvar k = 0; k < DIGIT; k++) begin : g_bit
      serial_alu_bit u_bit (
        .op (req_q.op),
        .a  (req_q.a[k]),
        .b  (req_q.b[k]),
        .ci (cy[k]),
        .r  (dig_r[k]),
        .co (cy[k+1])
      );
    end
  endgenerate

  // New digit enters at the top so that after N shifts bit 0 is the LSB.
  always_comb begin
    dig_ext = '0;
    dig_ext[DIGIT-1:0] = dig_r;
  end
  assign res_next = (res_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start && bus.opcode != OP_NOP) begin
        accept  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (cnt_q == LAST) begin
        last    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cf_q    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      vf_q    <= 1'b0;
`endif
    end else begin
      done_q <= last;
      if (accept) begin
        req_q   <= '{op: bus.opcode, a: bus.a, b: bus.b};
        res_q   <= '0;
        carry_q <= (bus.opcode == OP_SUB);
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (state_q == S_RUN) begin
        req_q.a <= req_q.a >> DIGIT;
        req_q.b <= req_q.b >> DIGIT;
        res_q   <= res_next;
        if (arith) carry_q <= cy[DIGIT];
        if (last) begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          // Flags come from the completed word, including this final digit.
          c_q    <= res_next;
          zf_q   <= (res_next == '0);
          sf_q   <= res_next[WIDTH-1];
          cf_q   <= arith & cy[DIGIT];
`ifdef SERIAL_ALU_OVF_EN
          vf_q   <= arith & (cy[DIGIT] ^ cy[DIGIT-1]);
`endif
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.c    = c_q;
  assign bus.zf   = zf_q;
  assign bus.sf   = sf_q;
  assign bus.cf   = cf_q;
`ifdef SERIAL_ALU_OVF_EN
  assign bus.vf   = vf_q;
`endif
endmodule

// File: tb/tb_serial_alu_param.sv
// Bench for serial_alu_param: two instances (DIGIT=1 and DIGIT=4, WIDTH=8)
// receive identical stimulus; table-driven vectors plus hand sequences for
// reset, NOP and busy-time START.
module tb_serial_alu_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_alu_param_if #(.WIDTH(8)) b1 ();
  serial_alu_param_if #(.WIDTH(8)) b4 ();

  serial_alu_param #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  serial_alu_param #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       zf;
    logic       sf;
    logic       cf;
    logic       vf;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    b1.start = s; b1.opcode = op; b1.a = a; b1.b = b;
    b4.start = s; b4.opcode = op; b4.a = a; b4.b = b;
  endtask

  // Waits for both DUTs to be idle, issues one op, measures latency and busy length.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int g, n, l1, l4, bc1, bc4;
    g = 0;
    while ((b1.busy || b1.done || b4.busy || b4.done) && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk({tag, "_idle_wait"}, 32'(g < 50), 32'd1);
    drive(1'b1, op, a, b);
    @(posedge clk); #1;
    drive(1'b0, 3'b000, ~a, ~b);   // operands must have been latched
    n = 0; l1 = -1; l4 = -1; bc1 = 0; bc4 = 0;
    while (n <= 20) begin
      if (b1.busy) bc1++;
      if (b4.busy) bc4++;
      if (b1.done && l1 < 0) l1 = n;
      if (b4.done && l4 < 0) l4 = n;
      if (l1 >= 0 && l4 >= 0) break;
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat_d1"}, 32'(l1), 32'd8);
    chk({tag, "_lat_d4"}, 32'(l4), 32'd2);
    chk({tag, "_busy_d1"}, 32'(bc1), 32'd8);
    chk({tag, "_busy_d4"}, 32'(bc4), 32'd2);
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, "_c_d1"},  32'(b1.c),  32'(v.c));
    chk({tag, "_zf_d1"}, 32'(b1.zf), 32'(v.zf));
    chk({tag, "_sf_d1"}, 32'(b1.sf), 32'(v.sf));
    chk({tag, "_cf_d1"}, 32'(b1.cf), 32'(v.cf));
    chk({tag, "_c_d4"},  32'(b4.c),  32'(v.c));
    chk({tag, "_zf_d4"}, 32'(b4.zf), 32'(v.zf));
    chk({tag, "_sf_d4"}, 32'(b4.sf), 32'(v.sf));
    chk({tag, "_cf_d4"}, 32'(b4.cf), 32'(v.cf));
`ifdef SERIAL_ALU_OVF_EN
    chk({tag, "_vf_d1"}, 32'(b1.vf), 32'(v.vf));
    chk({tag, "_vf_d4"}, 32'(b4.vf), 32'(v.vf));
`endif
  endtask

  vec_t vt[11];

  initial begin
    int seen;
    //          op      a      b      c     zf    sf    cf    vf
    vt[0]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};  // ADD wrap
    vt[1]  = '{3'b100, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};  // SUB borrow
    vt[2]  = '{3'b100, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};  // SUB no borrow
    vt[3]  = '{3'b011, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};  // XNOR
    vt[4]  = '{3'b111, 8'h80, 8'h33, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};  // PASS, back to back
    vt[5]  = '{3'b001, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b0};  // XOR
    vt[6]  = '{3'b101, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};  // AND
    vt[7]  = '{3'b110, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};  // OR
    vt[8]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};  // ADD signed ovf
    vt[9]  = '{3'b100, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};  // SUB equal
    vt[10] = '{3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};  // ADD plain

    drive(1'b0, 3'b000, 8'h00, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("reset_d1", 32'({b1.busy, b1.done, b1.zf, b1.sf, b1.cf, b1.c}), 32'd0);
    chk("reset_d4", 32'({b4.busy, b4.done, b4.zf, b4.sf, b4.cf, b4.c}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("v%0d", i), vt[i].op, vt[i].a, vt[i].b);
      chk_out($sformatf("v%0d", i), vt[i]);
    end

    // START with new operands while busy: ignored by both instances.
    run_op("bz", 3'b010, 8'h12, 8'h34);
    chk_out("bz_ref", vt[10]);
    while (b1.busy || b1.done || b4.busy || b4.done) begin @(posedge clk); #1; end
    drive(1'b1, 3'b010, 8'h12, 8'h34);
    @(posedge clk); #1;
    drive(1'b1, 3'b100, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    seen = 0;
    while (!b1.done && seen < 20) begin @(posedge clk); #1; seen++; end
    chk("bz_done_seen", 32'(seen < 20), 32'd1);
    chk_out("bz", vt[10]);

    // NOP START: no busy, no done, result held.
    @(posedge clk); #1;
    drive(1'b1, 3'b000, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (b1.busy || b1.done || b4.busy || b4.done) seen++;
      @(posedge clk); #1;
    end
    chk("nop_quiet", 32'(seen), 32'd0);
    chk_out("nop_hold", vt[10]);

    // Reset in cycle 4 of an ADD: everything clears at once, no DONE follows.
    drive(1'b1, 3'b010, 8'hFF, 8'h01);
    @(posedge clk); #1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy_before", 32'(b1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_d1", 32'({b1.busy, b1.done, b1.zf, b1.sf, b1.cf, b1.c}), 32'd0);
    chk("mid_rst_d4", 32'({b4.busy, b4.done, b4.zf, b4.sf, b4.cf, b4.c}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (b1.done || b1.busy || b4.done || b4.busy) seen++;
    end
    chk("mid_no_done", 32'(seen), 32'd0);
    run_op("post", vt[2].op, vt[2].a, vt[2].b);
    chk_out("post", vt[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
